// File: rtl/bram_block_pkg.sv
// Shared constants and helpers for the dual-port block RAM slice.
// Optional build macro used by this slice: BRAM_BLOCK_COLLISION_DETECT_EN.
package bram_block_pkg;

  localparam int unsigned BYTE_W = 8;

  // Write-mode codes used for same-port read-during-write behaviour
  localparam int unsigned WM_READ_FIRST  = 0;
  localparam int unsigned WM_WRITE_FIRST = 1;
  localparam int unsigned WM_NO_CHANGE   = 2;

  // Ceiling log2, usable in constant expressions
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

  // Word index: drop byte-offset bits, wrap the rest modulo the memory size
  function automatic int unsigned wordIndex(input logic [63:0] addr,
                                            input int unsigned memSize,
                                            input int unsigned numWe);
    logic [63:0] offset;
    offset = (addr & (64'(memSize) - 64'd1)) >> clog2(numWe);
    return 32'(offset);
  endfunction

endpackage

// File: rtl/bram_block_dp_pipelined_if.sv
// Bus bundle for both BRAM ports. The controller side uses 'master',
// the memory uses 'slave'. With BRAM_BLOCK_COLLISION_DETECT_EN defined the
// bundle also carries the collision pulse and counter.
interface bram_block_dp_pipelined_if #(
  parameter int unsigned C_PORT_DWIDTH = 32,
  parameter int unsigned C_PORT_AWIDTH = 32,
  parameter int unsigned C_NUM_WE      = C_PORT_DWIDTH / 8
);

  logic                     BRAM_EN_A;
  logic [0:C_NUM_WE-1]      BRAM_WEN_A;
  logic [0:C_PORT_AWIDTH-1] BRAM_Addr_A;
  logic [0:C_PORT_DWIDTH-1] BRAM_Dout_A;
  logic [0:C_PORT_DWIDTH-1] BRAM_Din_A;

  logic                     BRAM_EN_B;
  logic [0:C_NUM_WE-1]      BRAM_WEN_B;
  logic [0:C_PORT_AWIDTH-1] BRAM_Addr_B;
  logic [0:C_PORT_DWIDTH-1] BRAM_Dout_B;
  logic [0:C_PORT_DWIDTH-1] BRAM_Din_B;

`ifdef BRAM_BLOCK_COLLISION_DETECT_EN
  logic                     Collision;
  logic [0:15]              Collision_Count;

  modport master (
    output BRAM_EN_A, BRAM_WEN_A, BRAM_Addr_A, BRAM_Dout_A,
    output BRAM_EN_B, BRAM_WEN_B, BRAM_Addr_B, BRAM_Dout_B,
    input  BRAM_Din_A, BRAM_Din_B, Collision, Collision_Count
  );

  modport slave (
    input  BRAM_EN_A, BRAM_WEN_A, BRAM_Addr_A, BRAM_Dout_A,
    input  BRAM_EN_B, BRAM_WEN_B, BRAM_Addr_B, BRAM_Dout_B,
    output BRAM_Din_A, BRAM_Din_B, Collision, Collision_Count
  );
`else
  modport master (
    output BRAM_EN_A, BRAM_WEN_A, BRAM_Addr_A, BRAM_Dout_A,
    output BRAM_EN_B, BRAM_WEN_B, BRAM_Addr_B, BRAM_Dout_B,
    input  BRAM_Din_A, BRAM_Din_B
  );

  modport slave (
    input  BRAM_EN_A, BRAM_WEN_A, BRAM_Addr_A, BRAM_Dout_A,
    input  BRAM_EN_B, BRAM_WEN_B, BRAM_Addr_B, BRAM_Dout_B,
    output BRAM_Din_A, BRAM_Din_B
  );
`endif

endinterface

// File: rtl/bram_block_port.sv
// One BRAM port: word-index decode, write-lane gating, read-during-write
// mux and the 1- or 2-stage read pipeline. The shared array lives in the top.
module bram_block_port
  import bram_block_pkg::*;
#(
  parameter int unsigned C_MEMSIZE      = 'h8000,
  parameter int unsigned C_PORT_DWIDTH  = 32,
  parameter int unsigned C_PORT_AWIDTH  = 32,
  parameter int unsigned C_NUM_WE       = 4,
  parameter int unsigned C_READ_LATENCY = 1,
  parameter int unsigned C_WRITE_MODE   = WM_READ_FIRST,
  parameter int unsigned IDX_W          = 13
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_en,
  input  logic [0:C_NUM_WE-1]      i_wen,
  input  logic [0:C_PORT_AWIDTH-1] i_addr,
  input  logic [0:C_PORT_DWIDTH-1] i_dout,
  input  logic [0:C_PORT_DWIDTH-1] i_memWord,
  output logic [IDX_W-1:0]         o_idx,
  output logic [0:C_NUM_WE-1]      o_laneWe,
  output logic [0:C_PORT_DWIDTH-1] o_din
);

  logic [0:C_PORT_DWIDTH-1] w_merged;
  logic [0:C_PORT_DWIDTH-1] r_arrayOut;

  assign o_idx    = IDX_W'(wordIndex(64'(i_addr), C_MEMSIZE, C_NUM_WE));
  assign o_laneWe = (i_en && !i_rst) ? i_wen : '0;

  // Post-write view of the addressed word as seen by this port alone
  always_comb begin
    w_merged = i_memWord;
    for (int i = 0; i < int'(C_NUM_WE); i++) begin
      if (i_wen[i]) begin
        w_merged[i*BYTE_W +: BYTE_W] = i_dout[i*BYTE_W +: BYTE_W];
      end
    end
  end

  // Array output register; the write mode picks what a writing access returns
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_arrayOut <= '0;
    end else if (i_en) begin
      if (|i_wen) begin
        if (C_WRITE_MODE == WM_WRITE_FIRST) begin
          r_arrayOut <= w_merged;
        end else if (C_WRITE_MODE == WM_NO_CHANGE) begin
          r_arrayOut <= r_arrayOut;
        end else begin
          r_arrayOut <= i_memWord;
        end
      end else begin
        r_arrayOut <= i_memWord;
      end
    end
  end

  generate
    if (C_READ_LATENCY == 2) begin : g_lat2
      logic [0:C_PORT_DWIDTH-1] r_outReg;

      // Extra output stage re-samples the array register every cycle
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          r_outReg <= '0;
        end else begin
          r_outReg <= r_arrayOut;
        end
      end

      assign o_din = r_outReg;
    end else begin : g_lat1
      assign o_din = r_arrayOut;
    end
  endgenerate

endmodule

// File: rtl/bram_block_dp_pipelined.sv
// True dual-port block RAM on a single clock with configurable size, width,
// read latency and per-port write mode. Port A wins lanes written by both
// ports in the same cycle. Optional macro: BRAM_BLOCK_COLLISION_DETECT_EN
// adds a collision pulse and a saturating collision counter.
module bram_block_dp_pipelined
  import bram_block_pkg::*;
#(
  parameter int unsigned C_MEMSIZE      = 'h8000,
  parameter int unsigned C_PORT_DWIDTH  = 32,
  parameter int unsigned C_PORT_AWIDTH  = 32,
  parameter int unsigned C_NUM_WE       = C_PORT_DWIDTH / 8,
  parameter int unsigned C_READ_LATENCY = 1,
  parameter string       C_WRITE_MODE_A = "READ_FIRST",
  parameter string       C_WRITE_MODE_B = "READ_FIRST"
) (
  input  logic                       BRAM_Clk,
  input  logic                       BRAM_Rst,
  bram_block_dp_pipelined_if.slave   bus
);

  localparam int unsigned DEPTH = C_MEMSIZE / C_NUM_WE;
  localparam int unsigned IDX_W = clog2(C_MEMSIZE) - clog2(C_NUM_WE);
  localparam int unsigned WM_A  = (C_WRITE_MODE_A == "WRITE_FIRST") ? WM_WRITE_FIRST :
                                  (C_WRITE_MODE_A == "NO_CHANGE")   ? WM_NO_CHANGE : WM_READ_FIRST;
  localparam int unsigned WM_B  = (C_WRITE_MODE_B == "WRITE_FIRST") ? WM_WRITE_FIRST :
                                  (C_WRITE_MODE_B == "NO_CHANGE")   ? WM_NO_CHANGE : WM_READ_FIRST;

  generate
    if (C_PORT_DWIDTH % 8 != 0) begin : g_errDwidth
      $error("C_PORT_DWIDTH must be a multiple of 8");
    end
    if (C_READ_LATENCY != 1 && C_READ_LATENCY != 2) begin : g_errLatency
      $error("C_READ_LATENCY must be 1 or 2");
    end
    if (C_MEMSIZE == 0 || (C_MEMSIZE & (C_MEMSIZE - 1)) != 0) begin : g_errMemsize
      $error("C_MEMSIZE must be a power of two");
    end
    if (C_NUM_WE != C_PORT_DWIDTH / 8) begin : g_errNumWe
      $error("C_NUM_WE must equal C_PORT_DWIDTH/8");
    end
    if (C_MEMSIZE < C_NUM_WE * 2) begin : g_errDepth
      $error("C_MEMSIZE must be at least 2 words");
    end
    if (C_WRITE_MODE_A != "READ_FIRST" && C_WRITE_MODE_A != "WRITE_FIRST" &&
        C_WRITE_MODE_A != "NO_CHANGE") begin : g_errModeA
      $error("C_WRITE_MODE_A is not a recognised write mode");
    end
    if (C_WRITE_MODE_B != "READ_FIRST" && C_WRITE_MODE_B != "WRITE_FIRST" &&
        C_WRITE_MODE_B != "NO_CHANGE") begin : g_errModeB
      $error("C_WRITE_MODE_B is not a recognised write mode");
    end
  endgenerate

  logic [0:C_PORT_DWIDTH-1] r_mem [0:DEPTH-1] = '{default: '0};

  logic [IDX_W-1:0]         w_idxA;
  logic [IDX_W-1:0]         w_idxB;
  logic [0:C_NUM_WE-1]      w_laneWeA;
  logic [0:C_NUM_WE-1]      w_laneWeB;
  logic [0:C_PORT_DWIDTH-1] w_wordA;
  logic [0:C_PORT_DWIDTH-1] w_wordB;

  assign w_wordA = r_mem[w_idxA];
  assign w_wordB = r_mem[w_idxB];

  bram_block_port #(
    .C_MEMSIZE(C_MEMSIZE), .C_PORT_DWIDTH(C_PORT_DWIDTH), .C_PORT_AWIDTH(C_PORT_AWIDTH),
    .C_NUM_WE(C_NUM_WE), .C_READ_LATENCY(C_READ_LATENCY), .C_WRITE_MODE(WM_A), .IDX_W(IDX_W)
  ) u_portA (
    .i_clk(BRAM_Clk), .i_rst(BRAM_Rst), .i_en(bus.BRAM_EN_A), .i_wen(bus.BRAM_WEN_A),
    .i_addr(bus.BRAM_Addr_A), .i_dout(bus.BRAM_Dout_A), .i_memWord(w_wordA),
    .o_idx(w_idxA), .o_laneWe(w_laneWeA), .o_din(bus.BRAM_Din_A)
  );

  bram_block_port #(
    .C_MEMSIZE(C_MEMSIZE), .C_PORT_DWIDTH(C_PORT_DWIDTH), .C_PORT_AWIDTH(C_PORT_AWIDTH),
    .C_NUM_WE(C_NUM_WE), .C_READ_LATENCY(C_READ_LATENCY), .C_WRITE_MODE(WM_B), .IDX_W(IDX_W)
  ) u_portB (
    .i_clk(BRAM_Clk), .i_rst(BRAM_Rst), .i_en(bus.BRAM_EN_B), .i_wen(bus.BRAM_WEN_B),
    .i_addr(bus.BRAM_Addr_B), .i_dout(bus.BRAM_Dout_B), .i_memWord(w_wordB),
    .o_idx(w_idxB), .o_laneWe(w_laneWeB), .o_din(bus.BRAM_Din_B)
  );

  // Lane writes; port A is applied last so it overrides port B on shared lanes
  always_ff @(posedge BRAM_Clk) begin
    for (int i = 0; i < int'(C_NUM_WE); i++) begin
      if (w_laneWeB[i]) begin
        r_mem[w_idxB][i*BYTE_W +: BYTE_W] <= bus.BRAM_Dout_B[i*BYTE_W +: BYTE_W];
      end
      if (w_laneWeA[i]) begin
        r_mem[w_idxA][i*BYTE_W +: BYTE_W] <= bus.BRAM_Dout_A[i*BYTE_W +: BYTE_W];
      end
    end
  end

`ifdef BRAM_BLOCK_COLLISION_DETECT_EN
  logic        w_collide;
  logic        r_collision;
  logic [0:15] r_collisionCount;

  assign w_collide = bus.BRAM_EN_A && bus.BRAM_EN_B && (w_idxA == w_idxB) &&
                     ((|bus.BRAM_WEN_A) || (|bus.BRAM_WEN_B));

  // One-cycle collision pulse and saturating event counter
  always_ff @(posedge BRAM_Clk) begin
    if (BRAM_Rst) begin
      r_collision      <= 1'b0;
      r_collisionCount <= '0;
    end else begin
      r_collision <= w_collide;
      if (w_collide && r_collisionCount != 16'hFFFF) begin
        r_collisionCount <= r_collisionCount + 16'd1;
      end
    end
  end

  assign bus.Collision       = r_collision;
  assign bus.Collision_Count = r_collisionCount;
`endif

endmodule

// File: tb/tb_bram_block_dp_pipelined.sv
// Directed bench for bram_block_dp_pipelined. Two instances share the same
// stimulus: dutL1 (latency 1, A READ_FIRST, B WRITE_FIRST) and
// dutL2 (latency 2, A NO_CHANGE, B READ_FIRST).
// Optional macro: BRAM_BLOCK_COLLISION_DETECT_EN enables the collision checks.
module tb_bram_block_dp_pipelined;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enA = 1'b0;
  logic        enB = 1'b0;
  logic [0:3]  wenA = '0;
  logic [0:3]  wenB = '0;
  logic [0:31] addrA = '0;
  logic [0:31] addrB = '0;
  logic [0:31] doutA = '0;
  logic [0:31] doutB = '0;

  int testsRun = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  bram_block_dp_pipelined_if #(.C_PORT_DWIDTH(32), .C_PORT_AWIDTH(32), .C_NUM_WE(4)) busL1 ();
  bram_block_dp_pipelined_if #(.C_PORT_DWIDTH(32), .C_PORT_AWIDTH(32), .C_NUM_WE(4)) busL2 ();

  assign busL1.BRAM_EN_A = enA;   assign busL2.BRAM_EN_A = enA;
  assign busL1.BRAM_WEN_A = wenA; assign busL2.BRAM_WEN_A = wenA;
  assign busL1.BRAM_Addr_A = addrA; assign busL2.BRAM_Addr_A = addrA;
  assign busL1.BRAM_Dout_A = doutA; assign busL2.BRAM_Dout_A = doutA;
  assign busL1.BRAM_EN_B = enB;   assign busL2.BRAM_EN_B = enB;
  assign busL1.BRAM_WEN_B = wenB; assign busL2.BRAM_WEN_B = wenB;
  assign busL1.BRAM_Addr_B = addrB; assign busL2.BRAM_Addr_B = addrB;
  assign busL1.BRAM_Dout_B = doutB; assign busL2.BRAM_Dout_B = doutB;

  bram_block_dp_pipelined #(
    .C_MEMSIZE('h8000), .C_PORT_DWIDTH(32), .C_PORT_AWIDTH(32), .C_NUM_WE(4),
    .C_READ_LATENCY(1), .C_WRITE_MODE_A("READ_FIRST"), .C_WRITE_MODE_B("WRITE_FIRST")
  ) dutL1 (.BRAM_Clk(clk), .BRAM_Rst(rst), .bus(busL1.slave));

  bram_block_dp_pipelined #(
    .C_MEMSIZE('h8000), .C_PORT_DWIDTH(32), .C_PORT_AWIDTH(32), .C_NUM_WE(4),
    .C_READ_LATENCY(2), .C_WRITE_MODE_A("NO_CHANGE"), .C_WRITE_MODE_B("READ_FIRST")
  ) dutL2 (.BRAM_Clk(clk), .BRAM_Rst(rst), .bus(busL2.slave));

  // Drive both ports, then advance one clock and settle past the edge
  task automatic applyStimulus(input logic iEnA, input logic [0:3] iWenA,
                               input logic [0:31] iAddrA, input logic [0:31] iDoutA,
                               input logic iEnB, input logic [0:3] iWenB,
                               input logic [0:31] iAddrB, input logic [0:31] iDoutB);
    enA = iEnA; wenA = iWenA; addrA = iAddrA; doutA = iDoutA;
    enB = iEnB; wenB = iWenB; addrB = iAddrB; doutB = iDoutB;
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 4'b0000, 32'h0, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0);
  endtask

  // Count one comparison and report it if the observed value is wrong
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  initial begin
    // Reset for two cycles
    idleCycle();
    idleCycle();
    checkOutput("rst_L1_DinA", busL1.BRAM_Din_A, 32'h0);
    checkOutput("rst_L1_DinB", busL1.BRAM_Din_B, 32'h0);
    checkOutput("rst_L2_DinA", busL2.BRAM_Din_A, 32'h0);
    checkOutput("rst_L2_DinB", busL2.BRAM_Din_B, 32'h0);
    rst = 1'b0;

    // Full write on A, read back on B at both latencies
    applyStimulus(1'b1, 4'b1111, 32'h10, 32'hDEADBEEF, 1'b0, 4'b0000, 32'h0, 32'h0);
    applyStimulus(1'b0, 4'b0000, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h10, 32'h0);
    checkOutput("full_wr_L1_DinB", busL1.BRAM_Din_B, 32'hDEADBEEF);
    checkOutput("full_wr_L2_not_yet", busL2.BRAM_Din_B, 32'h0);
    idleCycle();
    checkOutput("full_wr_L2_DinB", busL2.BRAM_Din_B, 32'hDEADBEEF);

    // Partial write of lane 1 only
    applyStimulus(1'b1, 4'b0100, 32'h10, 32'h00AA0000, 1'b0, 4'b0000, 32'h0, 32'h0);
    applyStimulus(1'b0, 4'b0000, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h10, 32'h0);
    checkOutput("part_wr_L1_DinB", busL1.BRAM_Din_B, 32'hDEAABEEF);
    checkOutput("part_wr_L2_old", busL2.BRAM_Din_B, 32'hDEADBEEF);
    idleCycle();
    checkOutput("part_wr_L2_DinB", busL2.BRAM_Din_B, 32'hDEAABEEF);

    // Same-port read-during-write on A @0x20 (old 0x11111111, new 0x22222222)
    applyStimulus(1'b1, 4'b1111, 32'h20, 32'h11111111, 1'b0, 4'b0000, 32'h0, 32'h0);
    applyStimulus(1'b1, 4'b0000, 32'h10, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0);
    applyStimulus(1'b1, 4'b1111, 32'h20, 32'h22222222, 1'b0, 4'b0000, 32'h0, 32'h0);
    checkOutput("rdw_read_first_L1_A", busL1.BRAM_Din_A, 32'h11111111);
    idleCycle();
    checkOutput("rdw_no_change_L2_A", busL2.BRAM_Din_A, 32'hDEAABEEF);

    // Same-port read-during-write on B @0x20, low two lanes
    applyStimulus(1'b0, 4'b0000, 32'h0, 32'h0, 1'b1, 4'b0011, 32'h20, 32'h00003333);
    checkOutput("rdw_write_first_L1_B", busL1.BRAM_Din_B, 32'h22223333);
    idleCycle();
    checkOutput("rdw_read_first_L2_B", busL2.BRAM_Din_B, 32'h22222222);

    // Both ports write the same word; A owns shared lanes
    applyStimulus(1'b1, 4'b1100, 32'h30, 32'hAAAAAAAA, 1'b1, 4'b0110, 32'h30, 32'hBBBBBBBB);
`ifdef BRAM_BLOCK_COLLISION_DETECT_EN
    checkOutput("coll_pulse_L1", 32'(busL1.Collision), 32'h1);
    checkOutput("coll_count_L1", 32'(busL1.Collision_Count), 32'h1);
`endif
    applyStimulus(1'b0, 4'b0000, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h30, 32'h0);
    checkOutput("dual_wr_L1_DinB", busL1.BRAM_Din_B, 32'hAAAABB00);
`ifdef BRAM_BLOCK_COLLISION_DETECT_EN
    checkOutput("coll_pulse_end_L1", 32'(busL1.Collision), 32'h0);
    checkOutput("coll_count_hold_L2", 32'(busL2.Collision_Count), 32'h1);
`endif
    idleCycle();
    checkOutput("dual_wr_L2_DinB", busL2.BRAM_Din_B, 32'hAAAABB00);

    // A writes while B reads the same word: B sees the pre-write word
    applyStimulus(1'b1, 4'b1111, 32'h40, 32'h55555555, 1'b1, 4'b0000, 32'h40, 32'h0);
    checkOutput("xport_rd_L1_DinB", busL1.BRAM_Din_B, 32'h0);
    idleCycle();
    checkOutput("xport_rd_L2_DinB", busL2.BRAM_Din_B, 32'h0);
`ifdef BRAM_BLOCK_COLLISION_DETECT_EN
    checkOutput("coll_count_two", 32'(busL1.Collision_Count), 32'h2);
`endif

    // Address aliasing modulo the memory size
    applyStimulus(1'b1, 4'b1111, 32'h8004, 32'h12345678, 1'b0, 4'b0000, 32'h0, 32'h0);
    applyStimulus(1'b0, 4'b0000, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0004, 32'h0);
    checkOutput("alias_L1_DinB", busL1.BRAM_Din_B, 32'h12345678);
    idleCycle();
    checkOutput("alias_L2_DinB", busL2.BRAM_Din_B, 32'h12345678);

    // Reset in the middle of a burst read, with a write that must be dropped
    applyStimulus(1'b1, 4'b0000, 32'h20, 32'h0, 1'b1, 4'b0000, 32'h10, 32'h0);
    rst = 1'b1;
    applyStimulus(1'b1, 4'b1111, 32'h10, 32'hFFFFFFFF, 1'b1, 4'b0000, 32'h10, 32'h0);
    checkOutput("midrst_L2_DinA", busL2.BRAM_Din_A, 32'h0);
    checkOutput("midrst_L2_DinB", busL2.BRAM_Din_B, 32'h0);
    checkOutput("midrst_L1_DinB", busL1.BRAM_Din_B, 32'h0);
`ifdef BRAM_BLOCK_COLLISION_DETECT_EN
    checkOutput("coll_count_rst", 32'(busL1.Collision_Count), 32'h0);
`endif
    rst = 1'b0;
    applyStimulus(1'b0, 4'b0000, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h10, 32'h0);
    checkOutput("postrst_L1_DinB", busL1.BRAM_Din_B, 32'hDEAABEEF);
    checkOutput("postrst_L2_not_yet", busL2.BRAM_Din_B, 32'h0);
    idleCycle();
    checkOutput("postrst_L2_DinB", busL2.BRAM_Din_B, 32'hDEAABEEF);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/bram_block_dp_pipelined.md
Name: bram_block_dp_pipelined

Overview:
Parametrised true dual-port block RAM for MicroBlaze local memory and video line/frame scratch use. It replaces the fixed 32 KiB / 32-bit elaborated BRAM block with configurable size, width, read latency and per-port write mode. Collision resolution between ports is deterministic. Both ports run on a single clock and are driven by the LMB BRAM interface controllers.

Parameters:
C_MEMSIZE, 'h8000, memory size in bytes; power of two, ≥ C_NUM_WE*2
C_PORT_DWIDTH, 32, data width in bits; multiple of 8 (8..64)
C_PORT_AWIDTH, 32, byte-address width
C_NUM_WE, C_PORT_DWIDTH/8, byte-lane write enables per port
C_READ_LATENCY, 1, 1 = array register only; 2 = extra output register
C_WRITE_MODE_A, "READ_FIRST", port A same-port read-during-write: "READ_FIRST" | "WRITE_FIRST" | "NO_CHANGE"
C_WRITE_MODE_B, "READ_FIRST", same options for port B

Ports:
BRAM_Clk  in  1  single clock for both ports
BRAM_Rst  in  1  synchronous, active-high reset
BRAM_EN_A  in  1  port A enable
BRAM_WEN_A  in  [0:C_NUM_WE-1]  port A byte write enables; bit 0 = lane [0:7]
BRAM_Addr_A  in  [0:C_PORT_AWIDTH-1]  port A byte address, bit 0 = MSB
BRAM_Dout_A  in  [0:C_PORT_DWIDTH-1]  port A write data (controller's Dout)
BRAM_Din_A  out  [0:C_PORT_DWIDTH-1]  port A read data (controller's Din)
BRAM_EN_B, BRAM_WEN_B, BRAM_Addr_B, BRAM_Dout_B, BRAM_Din_B  port B, identical to port A

Interface rule (already decided): one clock, BRAM_Clk; reset BRAM_Rst is synchronous and active-high.

Behaviour:
- Depth D = C_MEMSIZE/C_NUM_WE words.
- Word index = Addr[C_PORT_AWIDTH-clog2(C_MEMSIZE) : C_PORT_AWIDTH-1-clog2(C_NUM_WE)].
- Upper address bits are ignored, so addresses alias modulo C_MEMSIZE. Lower byte-offset bits are ignored.
- Write: on a rising edge with EN=1 and Rst=0, each lane i with WEN[i]=1 stores Dout[8i:8i+7]. Lanes with WEN=0 are unchanged.
- Read: on a rising edge with EN=1, the array output register loads the addressed word.
  - Latency 1: Din is valid in the cycle after the EN cycle.
  - Latency 2: an extra output register loads every non-reset cycle, so Din is valid two cycles after the EN cycle.
- EN=0: no write; the array register holds its value. At latency 2 the output register re-samples the held value.
- Same-port read-during-write (EN=1 with any WEN bit set):
  - READ_FIRST: Din returns the pre-write word.
  - WRITE_FIRST: Din returns the post-write word (merged lanes).
  - NO_CHANGE: the array register holds its previous value.
- Cross-port, same word:
  - One port writes while the other reads: the reader gets the pre-write word.
  - Both ports write: lanes written by both take port A data; lanes written by only one port take that port's data.
- Reset: while BRAM_Rst=1, all writes are suppressed and all Din registers (both stages, both ports) clear to 0 on the edge. Array contents are retained.
  - Reset asserted mid-burst: the in-flight read data is discarded and reads to 0.
  - First valid read after release arrives at normal latency.
- Memory power-up contents are 0 (array initialised in declaration). No INIT file in this block.
- Elaboration asserts (error, no silent clamp):
  - C_PORT_DWIDTH%8 == 0
  - C_READ_LATENCY ∈ {1,2}
  - C_MEMSIZE is a power of two
  - C_NUM_WE == C_PORT_DWIDTH/8

Optional Feature:
Macro: BRAM_BLOCK_COLLISION_DETECT_EN
- Defined: adds ports Collision (out, 1) and Collision_Count (out, [0:15]).
  - Collision pulses high for one cycle, one cycle after any edge where both EN=1, word indices match, and at least one WEN bit is set on either port.
  - Collision_Count increments on each such event, saturates at 'hFFFF, and clears on BRAM_Rst.
  - Data behaviour is unchanged.
- Undefined: ports and logic are absent.

Decomposition:
- Package bram_block_pkg holds:
  - write-mode constants WM_READ_FIRST / WM_WRITE_FIRST / WM_NO_CHANGE
  - BYTE_W = 8
  - clog2 function
  - word-index extraction function
- Sub-module bram_block_port, instantiated twice, holds one port's index decode, write-mode mux and latency pipeline.
- The shared array and cross-port lane arbitration stay in the top module.

Test Plan:
- Reset, then write A @0x10 WEN=1111 data 0xDEADBEEF; read B @0x10 (latency 1) → Din_B=0xDEADBEEF one cycle after EN.
- Partial write: WEN=0100 data 0x00AA0000 over 0xDEADBEEF → read returns 0xDEAABEEF. Repeat at latency 2 and confirm the 2-cycle delay.
- Same-port read-during-write on A @0x20 (old 0x11111111, new 0x22222222):
  - READ_FIRST → 0x11111111
  - WRITE_FIRST → 0x22222222
  - NO_CHANGE → previous Din_A held
- Both ports write @0x30 in the same cycle: A WEN=1100 data 0xAAAAAAAA, B WEN=0110 data 0xBBBBBBBB, old 0 → 0xAAAABB00.
  - With the macro defined: Collision pulses once, Collision_Count=1.
- Aliasing: write @0x8004 with C_MEMSIZE='h8000 → read @0x0004 returns the same data.
- Assert Rst during a burst read at latency 2 → both Din regs read 0 the next cycle, the WEN=1111 write in the reset cycle is not stored, and array data is intact after release.
